interrupt_controller: RTL

Collects single-cycle interrupt strobes from on-chip peripherals (timer0 COMPA/COMPB/OVF and others) into pending flags. Applies per-source masks and the global I flag, and presents one prioritized irq/vector pair to the CPU control unit. It sits between the peripherals and the CPU's CALL_ISR/RETI sequencing. Mask and flag registers are visible to software through the I/O bus (TIMSK/TIFR-style).

---
 rtl/interrupt_controller_pkg.sv | 45 ++++
 rtl/interrupt_controller_irq_priority_encoder.sv | 26 ++
 rtl/interrupt_controller.sv | 139 +++++++++++++
 3 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: default geometry, source
// index / vector assignment, I/O register addresses and FSM state encodings.
package interrupt_controller_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_I_ADDR_WIDTH  = 10;
    localparam int DEF_IO_ADDR_WIDTH = 6;
    localparam int DEF_NUM_IRQ       = 8;
    localparam int DEF_VECTOR_BASE   = 1;

    localparam logic [5:0] DEF_MASK_ADDR = 6'h39;
    localparam logic [5:0] DEF_FLAG_ADDR = 6'h38;

    // SREG bit holding the global interrupt enable
    localparam int FLAGS_I = 7;

    // Source index assignment; lower index wins arbitration
    localparam int SRC_TIM0_COMPA = 0;
    localparam int SRC_TIM0_COMPB = 1;
    localparam int SRC_TIM0_OVF   = 2;
    localparam int SRC_TIM1_COMPA = 3;
    localparam int SRC_TIM1_OVF   = 4;
    localparam int SRC_UART_RX    = 5;
    localparam int SRC_UART_TX    = 6;
    localparam int SRC_EXT_INT0   = 7;

    localparam logic [9:0] TIM0_COMPA_ISR = 10'(DEF_VECTOR_BASE + SRC_TIM0_COMPA);
    localparam logic [9:0] TIM0_COMPB_ISR = 10'(DEF_VECTOR_BASE + SRC_TIM0_COMPB);
    localparam logic [9:0] TIM0_OVF_ISR   = 10'(DEF_VECTOR_BASE + SRC_TIM0_OVF);
    localparam logic [9:0] TIM1_COMPA_ISR = 10'(DEF_VECTOR_BASE + SRC_TIM1_COMPA);
    localparam logic [9:0] TIM1_OVF_ISR   = 10'(DEF_VECTOR_BASE + SRC_TIM1_OVF);
    localparam logic [9:0] UART_RX_ISR    = 10'(DEF_VECTOR_BASE + SRC_UART_RX);
    localparam logic [9:0] UART_TX_ISR    = 10'(DEF_VECTOR_BASE + SRC_UART_TX);
    localparam logic [9:0] EXT_INT0_ISR   = 10'(DEF_VECTOR_BASE + SRC_EXT_INT0);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // Index width for n sources; a single source still needs one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/interrupt_controller_irq_priority_encoder.sv
// Fixed-priority encoder: lowest set request index wins.
// Latency: combinational. Backpressure: none, pure function of req.
// Valid is low when no request bit is set; index is then 0.
module irq_priority_encoder
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_IRQ = DEF_NUM_IRQ,
    parameter int IW      = idx_w(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [IW-1:0]      idx,
    output logic               vld
);

    always_comb begin
        idx = '0;
        vld = |req;
        // Scan downwards so the last assignment is the lowest set index
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Latches peripheral strobes into pending flags and presents one prioritized irq/vector.
// Latency: strobe -> flag next edge -> irq/vector the edge after. Backpressure: none;
// the CPU handshakes with irq_ack / reti, and no new request is raised while servicing.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int                       DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int                       I_ADDR_WIDTH  = DEF_I_ADDR_WIDTH,
    parameter int                       IO_ADDR_WIDTH = DEF_IO_ADDR_WIDTH,
    parameter int                       NUM_IRQ       = DEF_NUM_IRQ,
    parameter int                       VECTOR_BASE   = DEF_VECTOR_BASE,
    parameter logic [IO_ADDR_WIDTH-1:0] MASK_ADDR     = DEF_MASK_ADDR,
    parameter logic [IO_ADDR_WIDTH-1:0] FLAG_ADDR     = DEF_FLAG_ADDR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IRQ-1:0]       irq_req,
    input  logic                     global_en,
    input  logic                     irq_ack,
    input  logic                     reti,
    input  logic [IO_ADDR_WIDTH-1:0] io_addr,
    input  logic                     io_we,
    input  logic [DATA_WIDTH-1:0]    io_wdata,
    output logic [DATA_WIDTH-1:0]    io_rdata,
    output logic                     irq,
    output logic [I_ADDR_WIDTH-1:0]  vector,
    output logic [NUM_IRQ-1:0]       pending
);

    localparam int IW = idx_w(NUM_IRQ);

    logic [NUM_IRQ-1:0]      flags;
    logic [NUM_IRQ-1:0]      mask;
    logic [NUM_IRQ-1:0]      active;
    logic [NUM_IRQ-1:0]      flag_clr;
    logic [1:0]              state;
    logic [IW-1:0]           src;
    logic [IW-1:0]           win_idx;
    logic                    win_vld;
    logic                    mask_wr;
    logic                    flag_wr;
    logic                    ack_take;
    logic                    req_ok;
    logic [I_ADDR_WIDTH-1:0] win_vector;

    assign mask_wr    = io_we && (io_addr == MASK_ADDR);
    assign flag_wr    = io_we && (io_addr == FLAG_ADDR);
    assign ack_take   = irq_ack && (state == ST_PENDING);
    assign active     = flags & mask;
    assign req_ok     = global_en && win_vld;
    assign win_vector = I_ADDR_WIDTH'(VECTOR_BASE) + I_ADDR_WIDTH'(win_idx);
    assign pending    = flags;

    irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ),
        .IW      (IW)
    ) u_prio (
        .req (active),
        .idx (win_idx),
        .vld (win_vld)
    );

    always_comb begin
        flag_clr = '0;
        if (flag_wr) begin
            flag_clr = flag_clr | io_wdata[NUM_IRQ-1:0];
        end
        if (ack_take) begin
            flag_clr = flag_clr | (NUM_IRQ'(1) << src);
        end
    end

    // A strobe is never lost to a same-cycle clear: set is applied last
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= '0;
            mask  <= '0;
        end else begin
            flags <= (flags & ~flag_clr) | irq_req;
            if (mask_wr) begin
                mask <= io_wdata[NUM_IRQ-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            src    <= '0;
            irq    <= 1'b0;
            vector <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_ok) begin
                        state  <= ST_PENDING;
                        src    <= win_idx;
                        irq    <= 1'b1;
                        vector <= win_vector;
                    end
                end
                ST_PENDING: begin
                    // The CPU has already committed to the presented vector,
                    // so an ack outranks a same-cycle withdrawal
                    if (irq_ack) begin
                        state <= ST_SERVICE;
                        irq   <= 1'b0;
                    end else if (!req_ok) begin
                        state <= ST_IDLE;
                        irq   <= 1'b0;
                    end else begin
                        src    <= win_idx;
                        vector <= win_vector;
                    end
                end
                ST_SERVICE: begin
                    irq <= 1'b0;
                    if (reti) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        io_rdata = '0;
        if (io_addr == MASK_ADDR) begin
            io_rdata = DATA_WIDTH'(mask);
        end else if (io_addr == FLAG_ADDR) begin
            io_rdata = DATA_WIDTH'(flags);
        end
    end

endmodule
